alu_cmd_driver: RTL and testbench

Command-side initiator for the registered 8-bit ALU (`alu`). It accepts operation requests on a valid/ready interface and drives `A`/`B`/`ALU_Sel` into the ALU. It captures `ALU_Out`/`CarryOut` after the ALU's register latency and returns each result, in order, through a buffered valid/ready response port. It sits between a test or control sequencer and the ALU instance, and sustains one operation per cycle when the response consumer keeps up.

---
 rtl/alu_cmd_driver.sv | 191 +++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Command-side initiator for a registered 8-bit ALU; returns results in order through a small response FIFO.
// Latency: command accepted at edge E0 drives the ALU at E0, result captured at E2, rsp_valid from E2 (empty FIFO).
// Backpressure: credit-based; cmd_ready drops once FIFO occupancy plus in-flight ops reaches DEPTH, nothing is dropped.
// Optional reference-model checker enabled by defining ALU_CMD_DRIVER_CHECK_EN (adds mismatch/err_count ports).
module alu_cmd_driver #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [3:0]  cmd_sel,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_carry,
    output logic [3:0]  rsp_sel
`ifdef ALU_CMD_DRIVER_CHECK_EN
    ,
    output logic        mismatch,
    output logic [15:0] err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_CR = (AW+2)'(DEPTH);

    // One FIFO entry: the opcode travels with its result so the consumer can tell them apart.
    typedef struct packed {
        logic [3:0] sel;
        logic       carry;
        logic [7:0] data;
    } rsp_t;

    logic          s1_vld;
    logic          s2_vld;
    logic [3:0]    s1_sel;
    logic [3:0]    s2_sel;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   fifo_count;
    logic [AW+1:0] credit_used;
    logic          fifo_empty;
    logic          fifo_full;
    logic          cmd_fire;
    logic          push;
    logic          pop;
    rsp_t          mem [DEPTH];
    rsp_t          head;
    rsp_t          wr_entry;

    // Credits cover both the stored results and the two ops still inside the ALU pipe,
    // so a capture always finds a free slot.
    assign fifo_count  = wr_ptr - rd_ptr;
    assign credit_used = {1'b0, fifo_count}
                       + {{(AW+1){1'b0}}, s1_vld}
                       + {{(AW+1){1'b0}}, s2_vld};
    assign cmd_ready   = !reset && (credit_used < DEPTH_CR);
    assign cmd_fire    = cmd_valid && cmd_ready;

    // Pointers carry one extra wrap bit: equal indices with different wrap bits means full.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign rsp_valid = !reset && !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    // A pop in the same edge frees the slot, so a push against a full FIFO is still safe then.
    assign push      = s2_vld && (!fifo_full || pop);

    assign head      = mem[rd_ptr[AW-1:0]];
    assign rsp_data  = rsp_valid ? head.data  : 8'h00;
    assign rsp_carry = rsp_valid ? head.carry : 1'b0;
    assign rsp_sel   = rsp_valid ? head.sel   : 4'h0;

    assign wr_entry.sel   = s2_sel;
    assign wr_entry.carry = alu_carry;
    assign wr_entry.data  = alu_out;

    // ALU operand registers: loaded on accept, otherwise hold the last command.
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_a   <= 8'h00;
            alu_b   <= 8'h00;
            alu_sel <= 4'h0;
        end else if (cmd_fire) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
        end
    end

    // In-flight tracker: s1 = operands at ALU input, s2 = result sitting in the ALU output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s1_sel <= 4'h0;
            s2_sel <= 4'h0;
        end else begin
            s1_vld <= cmd_fire;
            s1_sel <= cmd_sel;
            s2_vld <= s1_vld;
            s2_sel <= s1_sel;
        end
    end

    // FIFO pointers; wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are only visible through rsp_valid so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

`ifdef ALU_CMD_DRIVER_CHECK_EN
    logic [8:0] model_sum;
    logic [7:0] model_dat;
    logic       model_cmp;
    logic [8:0] s1_exp;
    logic [8:0] s2_exp;
    logic       s1_cmp;
    logic       s2_cmp;
    logic       cap_bad;

    // Reference result from the incoming command; carry is always the add carry, whatever the opcode.
    always_comb begin
        model_sum = {1'b0, cmd_a} + {1'b0, cmd_b};
        model_dat = 8'hFF;
        model_cmp = 1'b1;
        case (cmd_sel)
            4'b0001: model_dat = model_sum[7:0];
            4'b0010: model_dat = cmd_a - cmd_b;
            4'b0100: model_dat = cmd_a * cmd_b;
            4'b1000: begin
                if (cmd_b == 8'h00) begin
                    model_cmp = 1'b0;
                end else begin
                    model_dat = cmd_a / cmd_b;
                end
            end
            default: model_dat = 8'hFF;
        endcase
    end

    assign cap_bad = s2_vld && s2_cmp && ({alu_carry, alu_out} != s2_exp);

    // Expected value rides the same two-stage pipe as the valid bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_exp <= 9'h000;
            s2_exp <= 9'h000;
            s1_cmp <= 1'b0;
            s2_cmp <= 1'b0;
        end else begin
            s1_exp <= {model_sum[8], model_dat};
            s1_cmp <= model_cmp;
            s2_exp <= s1_exp;
            s2_cmp <= s1_cmp;
        end
    end

    // Mismatch pulse on the capture edge and a saturating error counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            mismatch  <= 1'b0;
            err_count <= 16'h0000;
        end else begin
            mismatch <= cap_bad;
            if (cap_bad && (err_count != 16'hFFFF)) err_count <= err_count + 16'h0001;
        end
    end
`else
    // Checker not built: no model logic and no mismatch/err_count ports.
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [3:0]  cmd_sel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_carry;
    logic [3:0]  rsp_sel;
`ifdef ALU_CMD_DRIVER_CHECK_EN
    logic        mismatch;
    logic [15:0] err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_rsp    = 0;
    logic        corrupt = 1'b0;
    logic [12:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [12:0] held;

    alu_cmd_driver #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_sel(rsp_sel)
`ifdef ALU_CMD_DRIVER_CHECK_EN
        , .mismatch(mismatch), .err_count(err_count)
`endif
    );

    always #5 clock = ~clock;

    // Result rule: add/sub/mul mod 256, integer divide (0 divisor -> FF here), others FF; carry of A+B.
    function automatic logic [8:0] ref_op(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, r;
        ia = a;
        ib = b;
        case (sel)
            4'b0001: r = (ia + ib) % 256;
            4'b0010: r = (ia - ib + 256) % 256;
            4'b0100: r = (ia * ib) % 256;
            4'b1000: r = (ib == 0) ? 255 : ia / ib;
            default: r = 255;
        endcase
        return {((ia + ib) > 255), r[7:0]};
    endfunction

    // Registered ALU stand-in sharing the driver's reset.
    always @(posedge clock) begin
        if (reset) begin
            alu_out   <= 8'h00;
            alu_carry <= 1'b0;
        end else begin
            {alu_carry, alu_out} <= ref_op(alu_sel, alu_a, alu_b);
            if (corrupt) alu_out <= 8'h00;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock with scoreboard bookkeeping; handshakes judged at the falling edge.
    task automatic step();
        @(negedge clock);
        if (stalled) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_stable", {rsp_sel, rsp_carry, rsp_data}, held);
        end
        stalled = rsp_valid && !rsp_ready;
        held    = {rsp_sel, rsp_carry, rsp_data};
        if (cmd_valid && cmd_ready) begin
            exp_q.push_back({cmd_sel, ref_op(cmd_sel, cmd_a, cmd_b)});
            n_acc++;
        end
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got %0h, expected no response", {rsp_sel, rsp_carry, rsp_data});
            end else begin
                chk("rsp_order", {rsp_sel, rsp_carry, rsp_data}, exp_q.pop_front());
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !rsp_valid) break;
            step();
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_count", n_rsp, n_acc);
        stalled = 1'b0;
    endtask

    typedef struct {
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] dat;
        logic       car;
    } vec_t;

    vec_t tbl[10];

    task automatic edge1();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input vec_t v);
        cmd_valid = 1'b1;
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_sel   = v.sel;
    endtask

    // Single isolated op: operands at E0, nothing at E1, result after E2, consumed by E3.
    task automatic run_single(input vec_t v);
        rsp_ready = 1'b1;
        drive(v);
        chk("single_ready", cmd_ready, 1);
        edge1();
        cmd_valid = 1'b0;
        chk("single_alu_a", alu_a, v.a);
        chk("single_alu_b", alu_b, v.b);
        chk("single_alu_sel", alu_sel, v.sel);
        chk("single_e0_valid", rsp_valid, 0);
        edge1();
        chk("single_e1_valid", rsp_valid, 0);
        edge1();
        chk("single_e2_valid", rsp_valid, 1);
        chk("single_data", rsp_data, v.dat);
        chk("single_carry", rsp_carry, v.car);
        chk("single_sel", rsp_sel, v.sel);
        edge1();
        chk("single_e3_valid", rsp_valid, 0);
        chk("single_alu_hold", alu_a, v.a);
    endtask

    initial begin
        tbl[0] = '{4'b0001, 8'h0F, 8'h01, 8'h10, 1'b0};
        tbl[1] = '{4'b0001, 8'hFF, 8'h02, 8'h01, 1'b1};
        tbl[2] = '{4'b0100, 8'h10, 8'h10, 8'h00, 1'b0};
        tbl[3] = '{4'b0010, 8'h05, 8'h07, 8'hFE, 1'b0};
        tbl[4] = '{4'b1000, 8'h64, 8'h05, 8'h14, 1'b0};
        tbl[5] = '{4'b0011, 8'h01, 8'h01, 8'hFF, 1'b0};
        tbl[6] = '{4'b0001, 8'h80, 8'h80, 8'h00, 1'b1};
        tbl[7] = '{4'b0010, 8'hF0, 8'h20, 8'hD0, 1'b1};
        tbl[8] = '{4'b0100, 8'h0F, 8'h11, 8'hFF, 1'b0};
        tbl[9] = '{4'b1000, 8'hFF, 8'h10, 8'h0F, 1'b1};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_sel   = 4'h0;

        // Reset behaviour
        repeat (3) edge1();
        chk("reset_cmd_ready", cmd_ready, 0);
        reset = 1'b0;
        #1;
        chk("post_reset_cmd_ready", cmd_ready, 1);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_b", alu_b, 0);
        chk("reset_alu_sel", alu_sel, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_carry", rsp_carry, 0);
        chk("reset_rsp_sel", rsp_sel, 0);
`ifdef ALU_CMD_DRIVER_CHECK_EN
        chk("reset_mismatch", mismatch, 0);
        chk("reset_err_count", err_count, 0);
`endif

        // Table-driven isolated operations
        for (int i = 0; i < 10; i++) run_single(tbl[i]);

        // Back-to-back sub, div, unknown opcode: responses on consecutive cycles
        rsp_ready = 1'b1;
        drive(tbl[3]);
        edge1();
        drive(tbl[4]);
        chk("b2b_ready1", cmd_ready, 1);
        edge1();
        drive(tbl[5]);
        chk("b2b_ready2", cmd_ready, 1);
        edge1();
        cmd_valid = 1'b0;
        chk("b2b_v0", rsp_valid, 1);
        chk("b2b_d0", rsp_data, 8'hFE);
        edge1();
        chk("b2b_v1", rsp_valid, 1);
        chk("b2b_d1", rsp_data, 8'h14);
        edge1();
        chk("b2b_v2", rsp_valid, 1);
        chk("b2b_d2", rsp_data, 8'hFF);
        chk("b2b_s2", rsp_sel, 4'b0011);
        edge1();
        chk("b2b_end", rsp_valid, 0);

        // Backpressure: exactly DEPTH commands get in, then credits run out
        n_acc = 0;
        n_rsp = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_sel   = 4'b0001 << (i % 4);
            step();
        end
        chk("bp_accepts", n_acc, DEPTH);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);

        // Release and stream to 3*DEPTH ops total (pointer wrap)
        rsp_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (n_acc >= 3 * DEPTH) break;
            cmd_valid = 1'b1;
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_sel   = 4'($urandom);
            step();
        end
        chk("wrap_ops", n_acc, 3 * DEPTH);
        drain();

        // Reset one cycle after two accepts: everything discarded
        rsp_ready = 1'b1;
        drive(tbl[0]);
        edge1();
        drive(tbl[1]);
        edge1();
        cmd_valid = 1'b0;
        reset     = 1'b1;
        edge1();
        reset = 1'b0;
        #1;
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_sel", alu_sel, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        chk("mid_rst_rsp_sel", rsp_sel, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst_no_rsp", rsp_valid, 0);
            edge1();
        end
        run_single(tbl[0]);

        // Randomized traffic against the scoreboard
        exp_q.delete();
        n_acc = 0;
        n_rsp = 0;
        stalled = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(3) != 0);
            rsp_ready = ($urandom_range(2) != 0);
            cmd_a     = 8'($urandom);
            cmd_b     = ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom);
            case ($urandom_range(5))
                0: cmd_sel = 4'b0001;
                1: cmd_sel = 4'b0010;
                2: cmd_sel = 4'b0100;
                3: cmd_sel = 4'b1000;
                default: cmd_sel = 4'($urandom);
            endcase
            step();
        end
        drain();

`ifdef ALU_CMD_DRIVER_CHECK_EN
        // Corrupted ALU result is flagged once; divide by zero is ignored
        chk("chk_err_before", err_count, 0);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_a = 8'h01; cmd_b = 8'h01; cmd_sel = 4'b0001;
        edge1();
        cmd_valid = 1'b0;
        corrupt   = 1'b1;
        edge1();
        corrupt = 1'b0;
        chk("chk_mm_e1", mismatch, 0);
        edge1();
        chk("chk_mm_e2", mismatch, 1);
        chk("chk_err_e2", err_count, 1);
        chk("chk_bad_data", rsp_data, 8'h00);
        edge1();
        chk("chk_mm_e3", mismatch, 0);
        chk("chk_err_e3", err_count, 1);
        cmd_valid = 1'b1;
        cmd_a = 8'h05; cmd_b = 8'h00; cmd_sel = 4'b1000;
        edge1();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("chk_div0_mm", mismatch, 0);
            edge1();
        end
        chk("chk_div0_err", err_count, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
